ipv4_rx_pkt: RTL and testbench

- Parametrised IPv4 receive filter and deframer for DATA_W of 16 or 32.
- Sits between the MAC RX output and the transport (UDP) RX input.
- Parses the full header including options and validates it, including an RFC 1071 one's-complement checksum.
- Forwards only the payload, trimmed to Total Length, with registered outputs; signals drop, checksum error and mid-payload abort to downstream.

---
 rtl/ipv4_rx_pkt.sv | 242 ++++++++++++++++++++++++
 tb/tb_ipv4_rx_pkt.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_rx_pkt.sv
// IPv4 receive filter and deframer: parses and validates the header (options and
// RFC 1071 checksum included) and forwards only the payload, trimmed to Total Length.
module ipv4_rx_pkt #(
    parameter int                DATA_W         = 16,
    parameter int                LEN_W          = $clog2(DATA_W/8)+1,
    parameter int                ADDR_W         = 32,
    parameter bit                MATCH_SRC_ADDR = 1'b1,
    parameter bit                MATCH_DST_ADDR = 1'b1,
    parameter logic [ADDR_W-1:0] SRC_ADDR       = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [ADDR_W-1:0] DST_ADDR       = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [7:0]        PROTOCOL       = 8'd17
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              cancel_o,
    output logic              cs_err_o,
    output logic              drop_o
);

    localparam int NB = DATA_W / 8;

    generate
        if (DATA_W != 16 && DATA_W != 32) begin : g_bad_width
            $error("ipv4_rx_pkt: DATA_W must be 16 or 32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, DRAIN} state_t;

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] a, input int i);
        return a[ADDR_W-1-8*i -: 8];
    endfunction

    state_t            state_q, state_d;
    logic [6:0]        hcnt_q, hcnt_d;
    logic [15:0]       pcnt_q, pcnt_d;
    logic [15:0]       tlen_q, tlen_d;
    logic [15:0]       csum_q, csum_d;
    logic [3:0]        ihl_q, ihl_d;
    logic              drop_q, drop_d;
    logic              sent_q, sent_d;
    logic              vin_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;
    logic              out_cancel_q, out_cancel_d;
    logic              out_cs_err_q, out_cs_err_d;
    logic              out_drop_q, out_drop_d;

    logic [7:0]        lane_b;
    logic [6:0]        idx;
    logic [3:0]        ihl_n;
    logic [15:0]       tlen_n;
    logic              fld_bad;
    logic [15:0]       beat_sum;
    logic [6:0]        hlen;
    logic              hdr_last;
    logic [15:0]       hdr_bytes;
    logic              len_bad;
    logic              cs_bad;
    logic [15:0]       pay_len;
    logic [LEN_W-1:0]  fwd_len;
    logic [DATA_W-1:0] fwd_data;

    // Header field extraction and checksum for the current beat, keyed on absolute byte index
    always_comb begin
        ihl_n   = ihl_q;
        tlen_n  = tlen_q;
        fld_bad = 1'b0;
        lane_b  = '0;
        idx     = '0;
        for (int k = 0; k < NB; k++) begin
            lane_b = data_i[8*k +: 8];
            idx    = hcnt_q + 7'(k);
            case (idx)
                7'd0: begin
                    ihl_n = lane_b[3:0];
                    if (lane_b[7:4] != 4'd4 || lane_b[3:0] < 4'd5) fld_bad = 1'b1;
                end
                7'd2: tlen_n[15:8] = lane_b;
                7'd3: tlen_n[7:0]  = lane_b;
                7'd6: if (lane_b[5] || lane_b[4:0] != 5'd0) fld_bad = 1'b1;
                7'd7: if (lane_b != 8'd0) fld_bad = 1'b1;
                7'd9: if (lane_b != PROTOCOL) fld_bad = 1'b1;
                7'd12, 7'd13, 7'd14, 7'd15:
                    if (MATCH_SRC_ADDR && lane_b != addr_byte(SRC_ADDR, int'(idx) - 12)) fld_bad = 1'b1;
                7'd16, 7'd17, 7'd18, 7'd19:
                    if (MATCH_DST_ADDR && lane_b != addr_byte(DST_ADDR, int'(idx) - 16)) fld_bad = 1'b1;
                default: ;
            endcase
        end

        beat_sum = csum_q;
        for (int w = 0; w < NB/2; w++) begin
            beat_sum = ones_add(beat_sum, {data_i[16*w +: 8], data_i[16*w+8 +: 8]});
        end

        // A malformed IHL below 5 still consumes a minimal 20-byte header before dropping
        hlen      = (ihl_n < 4'd5) ? 7'd20 : {1'b0, ihl_n, 2'b00};
        hdr_last  = (hcnt_q + 7'(NB)) >= hlen;
        hdr_bytes = {10'd0, ihl_n, 2'b00};
        len_bad   = tlen_n < hdr_bytes;
        pay_len   = tlen_n - hdr_bytes;
        cs_bad    = beat_sum != 16'hFFFF;

        fwd_len  = (16'(len_i) > pcnt_q) ? pcnt_q[LEN_W-1:0] : len_i;
        fwd_data = '0;
        for (int k = 0; k < NB; k++) begin
            fwd_data[8*k +: 8] = (LEN_W'(k) < fwd_len) ? data_i[8*k +: 8] : 8'd0;
        end
    end

    // Every counter and flag defaults to cleared, so any return to IDLE leaves them at zero
    always_comb begin
        state_d      = state_q;
        hcnt_d       = '0;
        pcnt_d       = '0;
        tlen_d       = '0;
        csum_d       = '0;
        ihl_d        = '0;
        drop_d       = 1'b0;
        sent_d       = 1'b0;
        out_valid_d  = 1'b0;
        out_data_d   = '0;
        out_len_d    = '0;
        out_cancel_d = 1'b0;
        out_cs_err_d = 1'b0;
        out_drop_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a rising valid_i starts a frame; the tail of an abandoned frame is skipped
                if (valid_i && !vin_q && !cancel_i) begin
                    state_d = HEAD;
                    hcnt_d  = 7'(NB);
                    csum_d  = beat_sum;
                    ihl_d   = ihl_n;
                    tlen_d  = tlen_n;
                    drop_d  = fld_bad;
                end
            end
            HEAD: begin
                if (cancel_i || !valid_i) begin
                    state_d    = IDLE;
                    out_drop_d = 1'b1;
                end else if (hdr_last) begin
                    if (drop_q || fld_bad || cs_bad || len_bad) begin
                        state_d      = DRAIN;
                        out_drop_d   = 1'b1;
                        out_cs_err_d = cs_bad;
                    end else if (pay_len == 16'd0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = PAYLOAD;
                        pcnt_d  = pay_len;
                    end
                end else begin
                    hcnt_d = hcnt_q + 7'(NB);
                    csum_d = beat_sum;
                    ihl_d  = ihl_n;
                    tlen_d = tlen_n;
                    drop_d = drop_q | fld_bad;
                end
            end
            PAYLOAD: begin
                if (cancel_i) begin
                    state_d      = IDLE;
                    out_cancel_d = sent_q;
                end else if (!valid_i) begin
                    state_d      = IDLE;
                    out_cancel_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    out_len_d   = fwd_len;
                    out_data_d  = fwd_data;
                    pcnt_d      = pcnt_q - 16'(fwd_len);
                    sent_d      = 1'b1;
                    if (pcnt_q == 16'(fwd_len)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cancel_i || !valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        vin_q <= valid_i;
        if (!nreset) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            pcnt_q       <= '0;
            tlen_q       <= '0;
            csum_q       <= '0;
            ihl_q        <= '0;
            drop_q       <= 1'b0;
            sent_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_len_q    <= '0;
            out_cancel_q <= 1'b0;
            out_cs_err_q <= 1'b0;
            out_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            pcnt_q       <= pcnt_d;
            tlen_q       <= tlen_d;
            csum_q       <= csum_d;
            ihl_q        <= ihl_d;
            drop_q       <= drop_d;
            sent_q       <= sent_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_len_q    <= out_len_d;
            out_cancel_q <= out_cancel_d;
            out_cs_err_q <= out_cs_err_d;
            out_drop_q   <= out_drop_d;
        end
    end

    assign valid_o  = out_valid_q;
    assign data_o   = out_data_q;
    assign len_o    = out_len_q;
    assign cancel_o = out_cancel_q;
    assign cs_err_o = out_cs_err_q;
    assign drop_o   = out_drop_q;

endmodule

// File: tb/tb_ipv4_rx_pkt.sv
// Directed bench for ipv4_rx_pkt: one 16-bit and one 32-bit instance share clock and reset.
module tb_ipv4_rx_pkt;

    localparam logic [31:0] ADDR = 32'hCEC87F80;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;

    logic        c16 = 1'b0, v16 = 1'b0;
    logic [15:0] d16 = '0;
    logic [1:0]  l16 = '0;
    logic        vo16, co16, ce16, dr16;
    logic [15:0] do16;
    logic [1:0]  lo16;

    logic        c32 = 1'b0, v32 = 1'b0;
    logic [31:0] d32 = '0;
    logic [2:0]  l32 = '0;
    logic        vo32, co32, ce32, dr32;
    logic [31:0] do32;
    logic [2:0]  lo32;

    ipv4_rx_pkt #(.DATA_W(16)) u_dut16 (
        .clk(clk), .nreset(nreset), .cancel_i(c16), .valid_i(v16), .data_i(d16), .len_i(l16),
        .valid_o(vo16), .data_o(do16), .len_o(lo16), .cancel_o(co16), .cs_err_o(ce16), .drop_o(dr16)
    );

    ipv4_rx_pkt #(.DATA_W(32)) u_dut32 (
        .clk(clk), .nreset(nreset), .cancel_i(c32), .valid_i(v32), .data_i(d32), .len_i(l32),
        .valid_o(vo32), .data_o(do32), .len_o(lo32), .cancel_o(co32), .cs_err_o(ce32), .drop_o(dr32)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output recorders, index 0 = 16-bit instance, 1 = 32-bit instance
    int         nbeat[2]    = '{0, 0};
    int         on[2]       = '{0, 0};
    int         ncan[2]     = '{0, 0};
    int         ncs[2]      = '{0, 0};
    int         ndrop[2]    = '{0, 0};
    int         last_len[2] = '{0, 0};
    int         dcyc[2]     = '{0, 0};
    logic [7:0] ob [0:1][0:255];

    always @(negedge clk) begin
        if (vo16) begin
            for (int k = 0; k < 2; k++) if (k < int'(lo16)) ob[0][on[0]+k] <= do16[8*k +: 8];
            on[0]       <= on[0] + int'(lo16);
            nbeat[0]    <= nbeat[0] + 1;
            last_len[0] <= int'(lo16);
        end
        if (co16) ncan[0] <= ncan[0] + 1;
        if (ce16) ncs[0] <= ncs[0] + 1;
        if (dr16) begin
            ndrop[0] <= ndrop[0] + 1;
            dcyc[0]  <= cyc;
        end
        if (vo32) begin
            for (int k = 0; k < 4; k++) if (k < int'(lo32)) ob[1][on[1]+k] <= do32[8*k +: 8];
            on[1]       <= on[1] + int'(lo32);
            nbeat[1]    <= nbeat[1] + 1;
            last_len[1] <= int'(lo32);
        end
        if (co32) ncan[1] <= ncan[1] + 1;
        if (ce32) ncs[1] <= ncs[1] + 1;
        if (dr32) begin
            ndrop[1] <= ndrop[1] + 1;
            dcyc[1]  <= cyc;
        end
    end

    int         n_assert = 0;
    int         n_fail = 0;
    int         bb[2], bo[2], bc[2], bs[2], bd[2];
    int         drv_cyc [0:63];
    logic [7:0] fr [0:127];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        for (int w = 0; w < 2; w++) begin
            bb[w] = nbeat[w];
            bo[w] = on[w];
            bc[w] = ncan[w];
            bs[w] = ncs[w];
            bd[w] = ndrop[w];
        end
    endtask

    // Header with correct checksum (plus csum_adj), NOP options, payload A0,A1,..., padding EE
    task automatic build(input int ihl, input int tlen, input logic [7:0] proto,
                         input logic [7:0] flags, input logic [31:0] dst, input int csum_adj);
        logic [16:0] s;
        logic [15:0] cs;
        for (int i = 0; i < 128; i++) fr[i] = 8'hEE;
        fr[0] = {4'd4, 4'(ihl)};
        fr[1] = 8'h00;
        fr[2] = 8'(tlen >> 8);
        fr[3] = 8'(tlen);
        fr[4] = 8'h12;
        fr[5] = 8'h34;
        fr[6] = flags;
        fr[7] = 8'h00;
        fr[8] = 8'd64;
        fr[9] = proto;
        fr[10] = 8'h00;
        fr[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            fr[12+i] = ADDR[31-8*i -: 8];
            fr[16+i] = dst[31-8*i -: 8];
        end
        for (int i = 20; i < ihl*4; i++) fr[i] = 8'h01;
        for (int i = ihl*4; i < tlen; i++) fr[i] = 8'hA0 + 8'(i - ihl*4);
        s = '0;
        for (int i = 0; i < ihl*4; i += 2) begin
            s = 17'(s[15:0]) + 17'({fr[i], fr[i+1]});
            s = 17'(s[15:0] + 16'(s[16]));
        end
        cs = ~s[15:0] + 16'(csum_adj);
        fr[10] = cs[15:8];
        fr[11] = cs[7:0];
    endtask

    task automatic drive_beat(input bit w, input int base, input int n, input bit can);
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < n; k++) d[8*k +: 8] = fr[base+k];
        if (w) begin
            v32 = 1'b1; d32 = d; l32 = 3'(n); c32 = can;
        end else begin
            v16 = 1'b1; d16 = d[15:0]; l16 = 2'(n); c16 = can;
        end
    endtask

    task automatic send(input bit w, input int nbytes, input int cancel_beat, input int rst_beat);
        int nb, nbeats, rem;
        nb = w ? 4 : 2;
        nbeats = (nbytes + nb - 1) / nb;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            if (rst_beat >= 0 && i == rst_beat + 1) begin
                if (w) chk("mid_rst_outs32", 64'({vo32, co32, ce32, dr32, lo32, do32}), 64'd0);
                else   chk("mid_rst_outs16", 64'({vo16, co16, ce16, dr16, lo16, do16}), 64'd0);
            end
            if (i == rst_beat) nreset = 1'b0;
            if (rst_beat >= 0 && i == rst_beat + 2) nreset = 1'b1;
            rem = nbytes - i*nb;
            drv_cyc[i] = cyc;
            drive_beat(w, i*nb, (rem > nb) ? nb : rem, i == cancel_beat);
            if (i == cancel_beat) break;
        end
        @(negedge clk);
        v16 = 1'b0; c16 = 1'b0; d16 = '0; l16 = '0;
        v32 = 1'b0; c32 = 1'b0; d32 = '0; l32 = '0;
        nreset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input bit w, input int beats, input int nbytes,
                                input int last, input int can, input int cs, input int drop);
        int wi;
        wi = int'(w);
        chk({tag, "_beats"},  64'(nbeat[wi] - bb[wi]), 64'(beats));
        chk({tag, "_bytes"},  64'(on[wi] - bo[wi]),    64'(nbytes));
        if (beats > 0) chk({tag, "_last_len"}, 64'(last_len[wi]), 64'(last));
        chk({tag, "_cancel"}, 64'(ncan[wi] - bc[wi]),  64'(can));
        chk({tag, "_cs_err"}, 64'(ncs[wi] - bs[wi]),   64'(cs));
        chk({tag, "_drop"},   64'(ndrop[wi] - bd[wi]), 64'(drop));
        for (int i = 0; i < nbytes; i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(ob[wi][bo[wi]+i]), 64'(8'hA0 + 8'(i)));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs16", 64'({vo16, co16, ce16, dr16, lo16, do16}), 64'd0);
        chk("reset_outs32", 64'({vo32, co32, ce32, dr32, lo32, do32}), 64'd0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        mark(); build(5, 28, 8'd17, 8'h00, ADDR, 0); send(1'b0, 28, -1, -1);
        expect_frame("udp16", 1'b0, 4, 8, 2, 0, 0, 0);

        mark(); build(6, 31, 8'd17, 8'h00, ADDR, 0); send(1'b1, 46, -1, -1);
        expect_frame("opt32", 1'b1, 2, 7, 3, 0, 0, 0);

        mark(); build(5, 28, 8'd17, 8'h00, ADDR, 1); send(1'b0, 28, -1, -1);
        expect_frame("csum16", 1'b0, 0, 0, 0, 0, 1, 1);
        chk("csum16_drop_cycle", 64'(dcyc[0]), 64'(drv_cyc[9] + 1));

        mark(); build(5, 28, 8'd6, 8'h00, ADDR, 0); send(1'b1, 28, -1, -1);
        expect_frame("tcp32", 1'b1, 0, 0, 0, 0, 0, 1);

        mark(); build(5, 28, 8'd17, 8'h20, ADDR, 0); send(1'b0, 28, -1, -1);
        expect_frame("mf16", 1'b0, 0, 0, 0, 0, 0, 1);

        mark(); build(5, 28, 8'd17, 8'h40, ADDR, 0); send(1'b0, 28, -1, -1);
        expect_frame("df16", 1'b0, 4, 8, 2, 0, 0, 0);

        mark(); build(5, 28, 8'd17, 8'h00, 32'h0A000001, 0); send(1'b1, 28, -1, -1);
        expect_frame("dst32", 1'b1, 0, 0, 0, 0, 0, 1);

        mark(); build(5, 16, 8'd17, 8'h00, ADDR, 0); send(1'b1, 20, -1, -1);
        expect_frame("shortlen32", 1'b1, 0, 0, 0, 0, 0, 1);

        mark(); build(5, 32, 8'd17, 8'h00, ADDR, 0); send(1'b0, 32, 12, -1);
        expect_frame("cancel16", 1'b0, 2, 4, 2, 1, 0, 0);

        mark(); build(5, 28, 8'd17, 8'h00, ADDR, 0); send(1'b0, 28, -1, -1);
        expect_frame("after_cancel16", 1'b0, 4, 8, 2, 0, 0, 0);

        mark(); build(5, 28, 8'd17, 8'h00, ADDR, 0); send(1'b0, 24, -1, -1);
        expect_frame("trunc16", 1'b0, 2, 4, 2, 1, 0, 0);

        mark(); build(5, 28, 8'd17, 8'h00, ADDR, 0); send(1'b1, 12, -1, -1);
        expect_frame("hdrtrunc32", 1'b1, 0, 0, 0, 0, 0, 1);

        mark(); build(5, 36, 8'd17, 8'h00, ADDR, 0); send(1'b1, 36, -1, 6);
        expect_frame("rst32", 1'b1, 1, 4, 4, 0, 0, 0);

        mark(); build(5, 28, 8'd17, 8'h00, ADDR, 0); send(1'b1, 28, -1, -1);
        expect_frame("after_rst32", 1'b1, 2, 8, 4, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
